// File: rtl/ram_arbiter816_if.sv
// ram_arbiter816_if: CPU, DMA and RAM-side signal bundle of the block RAM arbiter.
// slave is the arbiter's view; master is the view of the surrounding buses and RAM.
interface ram_arbiter816_if #(
    parameter int AW = 20,
    parameter int DW = 8
);
    logic          cpu_cs;
    logic          cpu_rw;
    logic [AW-1:0] cpu_ad;
    logic [DW-1:0] cpu_dati;
    logic [DW-1:0] cpu_dato;
    logic          cpu_rdy;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_adr;
    logic [DW-1:0] dma_dati;
    logic [DW-1:0] dma_dato;
    logic          dma_ack;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  cpu_cs, cpu_rw, cpu_ad, cpu_dati,
        input  dma_req, dma_we, dma_adr, dma_dati,
        input  ram_dout,
        output cpu_dato, cpu_rdy, dma_dato, dma_ack,
        output ram_en, ram_we, ram_adr, ram_din
    );

    modport master (
        output cpu_cs, cpu_rw, cpu_ad, cpu_dati,
        output dma_req, dma_we, dma_adr, dma_dati,
        output ram_dout,
        input  cpu_dato, cpu_rdy, dma_dato, dma_ack,
        input  ram_en, ram_we, ram_adr, ram_din
    );
endinterface

// File: rtl/ram_arbiter816.sv
// ram_arbiter816: round-robin sharing of the single-port block RAM between the
// FT832 CPU bus and the DMA/blitter port, with read-latency sequencing, the CPU
// rdy wait-state and a one-cycle DMA ack.
module ram_arbiter816 #(
    parameter int AW     = 20,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    ram_arbiter816_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    // WAIT always lasts RD_LAT cycles so capture lines up with ram_dout valid.
    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t        state, state_nx;
    logic          take_cpu, take_dma;
    logic          en_c, we_c;
    logic          sel_dma;
    logic          last_dma;
    logic          we_q;
    logic          cpu_done;
    logic          dma_ack_q;
    logic [2:0]    cnt;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] cpu_dato_q;
    logic [DW-1:0] dma_dato_q;

    // Next-state, arbitration and RAM strobe decode.
    always_comb begin
        state_nx = state;
        take_cpu = 1'b0;
        take_dma = 1'b0;
        en_c     = 1'b0;
        we_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_cs && (!bus.dma_req || last_dma)) begin
                    take_cpu = 1'b1;
                    state_nx = ACCESS;
                end else if (bus.dma_req) begin
                    take_dma = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                en_c     = 1'b1;
                we_c     = we_q;
                state_nx = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latching, latency counter, read capture and completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_dma    <= 1'b0;
            last_dma   <= 1'b1;
            we_q       <= 1'b0;
            cnt        <= '0;
            adr_q      <= '0;
            din_q      <= '0;
            cpu_dato_q <= '0;
            dma_dato_q <= '0;
            cpu_done   <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            cpu_done  <= 1'b0;
            dma_ack_q <= 1'b0;
            if (take_cpu) begin
                adr_q    <= bus.cpu_ad;
                din_q    <= bus.cpu_dati;
                we_q     <= ~bus.cpu_rw;
                sel_dma  <= 1'b0;
                last_dma <= 1'b0;
            end
            if (take_dma) begin
                adr_q    <= bus.dma_adr;
                din_q    <= bus.dma_dati;
                we_q     <= bus.dma_we;
                sel_dma  <= 1'b1;
                last_dma <= 1'b1;
            end
            if (state == ACCESS && !we_q) begin
                cnt <= CNT_INIT;
            end
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 3'd1;
                end else if (sel_dma) begin
                    dma_dato_q <= bus.ram_dout;
                end else begin
                    cpu_dato_q <= bus.ram_dout;
                end
            end
            if (state_nx == DONE) begin
                if (sel_dma) begin
                    dma_ack_q <= 1'b1;
                end else begin
                    cpu_done <= 1'b1;
                end
            end
        end
    end

    assign bus.ram_en   = en_c;
    assign bus.ram_we   = we_c;
    assign bus.ram_adr  = adr_q;
    assign bus.ram_din  = din_q;
    assign bus.cpu_dato = cpu_dato_q;
    assign bus.dma_dato = dma_dato_q;
    assign bus.dma_ack  = dma_ack_q;
    assign bus.cpu_rdy  = ~bus.cpu_cs | cpu_done;
endmodule
